mux_arb_nx1: RTL and testbench

MUX_ARB_NX1 -- requirements
Module: mux_arb_nx1

---
 rtl/mux_arb_nx1_pkg.sv | 17 +
 rtl/mux_arb_nx1_rr_pick.sv | 31 +++
 rtl/mux_arb_nx1.sv | 102 ++++++++++
 tb/tb_mux_arb_nx1.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/mux_arb_nx1_pkg.sv
// Shared constants for the N:1 arbitrated mux: mode encodings, channel-count limits
// and the wrapping index increment used by the round-robin pointer.
package mux_arb_nx1_pkg;

   typedef enum logic {
      MODE_SEL = 1'b0,
      MODE_RR  = 1'b1
   } arbMode_e;

   localparam int NUM_IN_MIN = 2;
   localparam int NUM_IN_MAX = 16;

   function automatic int wrapInc(input int idx, input int n);
      return (idx >= n - 1) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/mux_arb_nx1_rr_pick.sv
// Round-robin search: first asserted request at or above ptr, wrapping to 0.
module rr_pick
   import mux_arb_nx1_pkg::*;
#(
   parameter int NUM_IN = 4,
   parameter int SEL_W  = $clog2(NUM_IN)
) (
   input  logic [NUM_IN-1:0] req,
   input  logic [SEL_W-1:0]  ptr,
   output logic              found,
   output logic [SEL_W-1:0]  idx
);

   logic [SEL_W:0] cand;

   always_comb begin
      found = 1'b0;
      idx   = '0;
      cand  = '0;
      for (int k = 0; k < NUM_IN; k++) begin
         // One extra bit so ptr+k never overflows before the modulo fold.
         cand = {1'b0, ptr} + (SEL_W+1)'(k);
         if (cand >= (SEL_W+1)'(NUM_IN)) cand = cand - (SEL_W+1)'(NUM_IN);
         if (!found && req[cand[SEL_W-1:0]]) begin
            found = 1'b1;
            idx   = cand[SEL_W-1:0];
         end
      end
   end

endmodule

// File: rtl/mux_arb_nx1.sv
// N:1 mux with explicit-select or round-robin arbitration into a single registered
// output word; drain and reload in the same cycle give one word per clock.
module mux_arb_nx1
   import mux_arb_nx1_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int NUM_IN = 4,
   parameter int SEL_W  = $clog2(NUM_IN)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_IN*WIDTH-1:0] D,
   input  logic [NUM_IN-1:0]       V,
   output logic [NUM_IN-1:0]       R,
   input  logic [SEL_W-1:0]        S,
   input  logic                    MODE,
   output logic [WIDTH-1:0]        F,
   output logic                    F_valid,
   input  logic                    F_ready,
   output logic [SEL_W-1:0]        F_sel
);

   // Handshake: a channel word moves when R[i] & V[i]; the output word moves when
   // F_valid & F_ready. R is only ever raised for a channel that is already valid.

   logic [WIDTH-1:0] fQ;
   logic [SEL_W-1:0] fSelQ;
   logic             fValidQ;
   logic [SEL_W-1:0] ptrQ;

   logic             space;
   logic             vAtS;
   logic             selInRange;
   logic             rrFound;
   logic [SEL_W-1:0] rrIdx;
   logic             grant;
   logic [SEL_W-1:0] gIdx;
   logic [WIDTH-1:0] dataSel;

   rr_pick #(
      .NUM_IN (NUM_IN),
      .SEL_W  (SEL_W)
   ) u_rrPick (
      .req   (V),
      .ptr   (ptrQ),
      .found (rrFound),
      .idx   (rrIdx)
   );

   always_comb begin
      space      = !fValidQ || F_ready;
      selInRange = ({1'b0, S} < (SEL_W+1)'(NUM_IN));
      vAtS       = 1'b0;
      for (int i = 0; i < NUM_IN; i++) begin
         if (S == SEL_W'(i)) vAtS = V[i];
      end

      if (MODE == MODE_RR) begin
         grant = rrFound && space;
         gIdx  = rrIdx;
      end else begin
         grant = selInRange && vAtS && space;
         gIdx  = S;
      end
      // Ready must stay low for the whole reset interval, not just until the next edge.
      grant = grant && rst_n;

      R       = '0;
      dataSel = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         if (gIdx == SEL_W'(i)) begin
            R[i]    = grant;
            dataSel = D[i*WIDTH +: WIDTH];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fQ      <= '0;
         fSelQ   <= '0;
         fValidQ <= 1'b0;
         ptrQ    <= '0;
      end else begin
         if (grant) begin
            fQ      <= dataSel;
            fSelQ   <= gIdx;
            fValidQ <= 1'b1;
         end else if (F_ready) begin
            fValidQ <= 1'b0;
         end
         if (grant && MODE == MODE_RR) begin
            ptrQ <= SEL_W'(wrapInc(int'(gIdx), NUM_IN));
         end
      end
   end

   assign F       = fQ;
   assign F_sel   = fSelQ;
   assign F_valid = fValidQ;

endmodule

// File: tb/tb_mux_arb_nx1.sv
// Directed bench for mux_arb_nx1 (4 channels x 32 bits) with hand-computed expectations.
module tb_mux_arb_nx1;

   localparam int WIDTH  = 32;
   localparam int NUM_IN = 4;
   localparam int SEL_W  = 2;

   localparam logic [31:0] CH0 = 32'h1111_0000;
   localparam logic [31:0] CH1 = 32'h2222_1111;
   localparam logic [31:0] CH2 = 32'hDEAD_BEEF;
   localparam logic [31:0] CH3 = 32'h4444_3333;

   logic                    clk;
   logic                    rst_n;
   logic [NUM_IN*WIDTH-1:0] D;
   logic [NUM_IN-1:0]       V;
   logic [NUM_IN-1:0]       R;
   logic [SEL_W-1:0]        S;
   logic                    MODE;
   logic [WIDTH-1:0]        F;
   logic                    F_valid;
   logic                    F_ready;
   logic [SEL_W-1:0]        F_sel;

   int checks = 0;
   int errors = 0;

   mux_arb_nx1 #(
      .WIDTH  (WIDTH),
      .NUM_IN (NUM_IN),
      .SEL_W  (SEL_W)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .D       (D),
      .V       (V),
      .R       (R),
      .S       (S),
      .MODE    (MODE),
      .F       (F),
      .F_valid (F_valid),
      .F_ready (F_ready),
      .F_sel   (F_sel)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // driver tasks
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic mode, input logic [SEL_W-1:0] sel,
                        input logic [NUM_IN-1:0] valid, input logic ready);
      MODE    = mode;
      S       = sel;
      V       = valid;
      F_ready = ready;
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic checkOut(input string tag, input logic [31:0] expF,
                           input logic expValid, input logic [SEL_W-1:0] expSel);
      check({tag, ".F"}, F, expF);
      check({tag, ".F_valid"}, 32'(F_valid), 32'(expValid));
      check({tag, ".F_sel"}, 32'(F_sel), 32'(expSel));
   endtask

   initial begin
      logic [SEL_W-1:0] rrSeq [6];
      logic [31:0]      rrData [6];
      rrSeq  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      rrData = '{CH0, CH1, CH2, CH3, CH0, CH1};

      D       = {CH3, CH2, CH1, CH0};
      rst_n   = 1'b0;
      MODE    = 1'b0;
      S       = '0;
      V       = 4'b1111;
      F_ready = 1'b1;
      #3;
      checkOut("reset", 32'h0, 1'b0, 2'd0);
      check("reset.R", 32'(R), 32'h0);
      repeat (2) step();
      check("reset_held.R", 32'(R), 32'h0);
      rst_n = 1'b1;

      // explicit select of channel 2
      drive(1'b0, 2'd2, 4'b0100, 1'b1);
      check("sel2.R", 32'(R), 32'b0100);
      step();
      checkOut("sel2.out", CH2, 1'b1, 2'd2);
      drive(1'b0, 2'd2, 4'b0000, 1'b1);
      check("idle.R", 32'(R), 32'h0);
      step();
      checkOut("drain", CH2, 1'b0, 2'd2);

      // selected channel not valid, then retarget to channel 0
      drive(1'b0, 2'd1, 4'b1101, 1'b1);
      check("sel1_invalid.R", 32'(R), 32'h0);
      step();
      check("sel1_invalid.F_valid", 32'(F_valid), 32'h0);
      drive(1'b0, 2'd0, 4'b1101, 1'b1);
      check("sel0.R", 32'(R), 32'b0001);
      step();
      checkOut("sel0.out", CH0, 1'b1, 2'd0);
      check("sel0.ptr", 32'(dut.ptrQ), 32'h0);
      drive(1'b0, 2'd0, 4'b0000, 1'b1);
      step();

      // round-robin, all channels valid, full throughput
      drive(1'b1, 2'd0, 4'b1111, 1'b1);
      for (int i = 0; i < 6; i++) begin
         check($sformatf("rr%0d.R", i), 32'(R), 32'(1 << rrSeq[i]));
         step();
         checkOut($sformatf("rr%0d", i), rrData[i], 1'b1, rrSeq[i]);
      end
      check("rr.ptr", 32'(dut.ptrQ), 32'd2);

      // move pointer to 3, then wrap on V=0011
      drive(1'b1, 2'd0, 4'b0100, 1'b1);
      step();
      check("rr_to3.ptr", 32'(dut.ptrQ), 32'd3);
      drive(1'b1, 2'd0, 4'b0011, 1'b1);
      check("wrap.R", 32'(R), 32'b0001);
      step();
      checkOut("wrap", CH0, 1'b1, 2'd0);
      check("wrap.ptr", 32'(dut.ptrQ), 32'd1);
      check("after_wrap.R", 32'(R), 32'b0010);
      step();
      checkOut("after_wrap", CH1, 1'b1, 2'd1);

      // backpressure holds the word and blocks all grants
      drive(1'b1, 2'd0, 4'b1111, 1'b0);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("stall%0d.R", i), 32'(R), 32'h0);
         step();
         checkOut($sformatf("stall%0d", i), CH1, 1'b1, 2'd1);
      end
      drive(1'b1, 2'd0, 4'b1111, 1'b1);
      check("release.R", 32'(R), 32'b0100);
      step();
      checkOut("release", CH2, 1'b1, 2'd2);

      // async reset mid-transfer with P=2
      drive(1'b1, 2'd0, 4'b0010, 1'b1);
      step();
      checkOut("pre_rst", CH1, 1'b1, 2'd1);
      check("pre_rst.ptr", 32'(dut.ptrQ), 32'd2);
      drive(1'b1, 2'd0, 4'b1111, 1'b0);
      rst_n = 1'b0;
      #1;
      checkOut("async_rst", 32'h0, 1'b0, 2'd0);
      check("async_rst.ptr", 32'(dut.ptrQ), 32'h0);
      check("async_rst.R", 32'(R), 32'h0);
      step();
      rst_n = 1'b1;
      drive(1'b1, 2'd0, 4'b1111, 1'b1);
      check("post_rst.R", 32'(R), 32'b0001);
      step();
      checkOut("post_rst", CH0, 1'b1, 2'd0);

      // final report
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
